// File: rtl/axi4l_if_if.sv
// AXI4-Lite bus bundle between a register-block slave and its master.
// Latency: none, wires only.
// Backpressure: carried by the ready/valid pairs of each of the five channels.
interface axi4l_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // write address channel
    logic [ADDR_WIDTH-1:0]   axi4l_awaddr;
    logic [2:0]              axi4l_awprot;
    logic                    axi4l_awvalid;
    logic                    axi4l_awready;
    // write data channel
    logic [DATA_WIDTH-1:0]   axi4l_wdata;
    logic [DATA_WIDTH/8-1:0] axi4l_wstrb;
    logic                    axi4l_wvalid;
    logic                    axi4l_wready;
    // write response channel
    logic [1:0]              axi4l_bresp;
    logic                    axi4l_bvalid;
    logic                    axi4l_bready;
    // read address channel
    logic [ADDR_WIDTH-1:0]   axi4l_araddr;
    logic [2:0]              axi4l_arprot;
    logic                    axi4l_arvalid;
    logic                    axi4l_arready;
    // read data channel
    logic [DATA_WIDTH-1:0]   axi4l_rdata;
    logic [1:0]              axi4l_rresp;
    logic                    axi4l_rvalid;
    logic                    axi4l_rready;

    modport master (
        output axi4l_awaddr, axi4l_awprot, axi4l_awvalid,
        input  axi4l_awready,
        output axi4l_wdata, axi4l_wstrb, axi4l_wvalid,
        input  axi4l_wready,
        input  axi4l_bresp, axi4l_bvalid,
        output axi4l_bready,
        output axi4l_araddr, axi4l_arprot, axi4l_arvalid,
        input  axi4l_arready,
        input  axi4l_rdata, axi4l_rresp, axi4l_rvalid,
        output axi4l_rready
    );

    modport slave (
        input  axi4l_awaddr, axi4l_awprot, axi4l_awvalid,
        output axi4l_awready,
        input  axi4l_wdata, axi4l_wstrb, axi4l_wvalid,
        output axi4l_wready,
        output axi4l_bresp, axi4l_bvalid,
        input  axi4l_bready,
        input  axi4l_araddr, axi4l_arprot, axi4l_arvalid,
        output axi4l_arready,
        output axi4l_rdata, axi4l_rresp, axi4l_rvalid,
        input  axi4l_rready
    );
endinterface

// File: rtl/axi4l_if.sv
// AXI4-Lite slave holding NUM_REGS 32-bit read/write registers, byte-strobed writes.
// Latency: B one edge after the later of AW/W is accepted; R one edge after AR.
// Backpressure: AW/W stall while a response is pending or the channel is held; AR stalls while rvalid.
// Optional feature: define AXI4L_IF_SLVERR_EN to answer out-of-range addresses with SLVERR
// (write dropped, rdata 0); otherwise upper address bits alias onto the register file.
module axi4l_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic       axi4l_aclk,
    input  logic       axi4l_arstn,   // active-high synchronous reset despite the name
    axi4l_if_if.slave  bus
);
    localparam int         IDX_W       = $clog2(NUM_REGS);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // write-side state
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    // read-side state
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    // register file
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  awready, wready, arready;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx;
    logic                  wr_err;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_err;
    logic                  unused_ok;

    // Readies are forced low during reset so nothing is accepted while state is clearing.
    assign awready = ~aw_held_q & ~bvalid_q & ~axi4l_arstn;
    assign wready  = ~w_held_q  & ~bvalid_q & ~axi4l_arstn;
    assign arready = ~rvalid_q  & ~axi4l_arstn;

    assign aw_hs = bus.axi4l_awvalid & awready;
    assign w_hs  = bus.axi4l_wvalid  & wready;
    assign ar_hs = bus.axi4l_arvalid & arready;

    // The write completes on the edge where the second of AW/W arrives; the other half
    // may be arriving this cycle or already parked in its holding register.
    assign wr_commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_addr   = aw_hs ? bus.axi4l_awaddr : awaddr_q;
    assign wr_data   = w_hs  ? bus.axi4l_wdata  : wdata_q;
    assign wr_strb   = w_hs  ? bus.axi4l_wstrb  : wstrb_q;
    assign wr_idx    = wr_addr[IDX_W+1:2];
    assign rd_addr   = bus.axi4l_araddr;
    assign rd_idx    = rd_addr[IDX_W+1:2];

`ifdef AXI4L_IF_SLVERR_EN
    assign wr_err = |wr_addr[ADDR_WIDTH-1:IDX_W+2];
    assign rd_err = |rd_addr[ADDR_WIDTH-1:IDX_W+2];
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    // Prot bits, byte-offset bits and (when aliasing) the upper address bits carry no meaning here.
    assign unused_ok = ^{bus.axi4l_awprot, bus.axi4l_arprot, wr_addr, rd_addr};

    // Write path: capture AW/W independently, commit when both present, retire B on bready.
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = bus.axi4l_awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = bus.axi4l_wdata;
            wstrb_d  = bus.axi4l_wstrb;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
            if (!wr_err) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end else if (bvalid_q && bus.axi4l_bready) begin
            // bresp is left as-is; it is only meaningful while bvalid is high
            bvalid_d = 1'b0;
        end
    end

    // Read path: sample the register file (pre-write value) on AR, hold R until rready.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err ? '0 : regs_q[rd_idx];
            rresp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && bus.axi4l_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers with synchronous reset clearing the register file and all handshake state.
    always_ff @(posedge axi4l_aclk) begin
        if (axi4l_arstn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Outputs read as zero/idle while reset is asserted, before the first edge has cleared them.
    assign bus.axi4l_awready = awready;
    assign bus.axi4l_wready  = wready;
    assign bus.axi4l_arready = arready;
    assign bus.axi4l_bvalid  = bvalid_q & ~axi4l_arstn;
    assign bus.axi4l_bresp   = axi4l_arstn ? 2'b00 : bresp_q;
    assign bus.axi4l_rvalid  = rvalid_q & ~axi4l_arstn;
    assign bus.axi4l_rresp   = axi4l_arstn ? 2'b00 : rresp_q;
    assign bus.axi4l_rdata   = axi4l_arstn ? '0 : rdata_q;

endmodule

// File: tb/tb_axi4l_if.sv
// Directed bench for the axi4l_if register slave.
// Latency: checks one-edge B and R timing.
// Backpressure: exercises bready/rready stalls and AW/W ordering.
module tb_axi4l_if;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    axi4l_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4l_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .axi4l_aclk  (clk),
        .axi4l_arstn (rst),
        .bus         (axi)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full write with AW and W presented together; waits (bounded) for B.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit aw_pend, w_pend, aw_fire, w_fire;
        int n;
        axi.axi4l_awaddr = addr;  axi.axi4l_awvalid = 1'b1;
        axi.axi4l_wdata  = data;  axi.axi4l_wstrb   = strb; axi.axi4l_wvalid = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_fire = axi.axi4l_awvalid && axi.axi4l_awready;
            w_fire  = axi.axi4l_wvalid  && axi.axi4l_wready;
            tick(); n++;
            if (aw_fire) begin axi.axi4l_awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_fire)  begin axi.axi4l_wvalid  = 1'b0; w_pend  = 1'b0; end
        end
        axi.axi4l_awvalid = 1'b0; axi.axi4l_wvalid = 1'b0;
        while (!axi.axi4l_bvalid && n < 40) begin tick(); n++; end
        ok   = axi.axi4l_bvalid && !aw_pend && !w_pend;
        resp = axi.axi4l_bresp;
        axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_bready = 1'b0;
    endtask

    // Full read; lat counts edges from the AR handshake edge to rvalid being seen (1 = next edge).
    task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat, output bit ok);
        bit fired;
        int n;
        axi.axi4l_araddr = addr; axi.axi4l_arvalid = 1'b1;
        fired = 1'b0; n = 0; lat = 0; ok = 1'b0; data = '0; resp = '0;
        while (!fired && n < 20) begin
            fired = axi.axi4l_arready;
            tick(); n++;
        end
        axi.axi4l_arvalid = 1'b0;
        if (!fired) return;
        lat = 1;
        while (!axi.axi4l_rvalid && lat < 20) begin tick(); lat++; end
        ok   = axi.axi4l_rvalid;
        data = axi.axi4l_rdata;
        resp = axi.axi4l_rresp;
        axi.axi4l_rready = 1'b1;
        tick();
        axi.axi4l_rready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        rst = 1'b1;
        repeat (10) tick();
        checks++; if (axi.axi4l_awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", axi.axi4l_awready); end
        checks++; if (axi.axi4l_wready  !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", axi.axi4l_wready); end
        checks++; if (axi.axi4l_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", axi.axi4l_arready); end
        checks++; if (axi.axi4l_bresp !== 2'b00 || axi.axi4l_rresp !== 2'b00) begin errors++; $display("FAIL rst_resp got b=%b r=%b want 00", axi.axi4l_bresp, axi.axi4l_rresp); end
        checks++; if (axi.axi4l_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", axi.axi4l_rdata); end
        checks++; if (axi.axi4l_bvalid !== 1'b0 || axi.axi4l_rvalid !== 1'b0) begin errors++; $display("FAIL rst_valids got b=%b r=%b want 0", axi.axi4l_bvalid, axi.axi4l_rvalid); end
        rst = 1'b0;
        tick();
        checks++; if ({axi.axi4l_awready, axi.axi4l_wready, axi.axi4l_arready} !== 3'b111) begin
            errors++; $display("FAIL post_rst_ready got %b want 111", {axi.axi4l_awready, axi.axi4l_wready, axi.axi4l_arready}); end
        read_txn(32'h04, d, r, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_read_timeout got 0 want 1"); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_read_data got %h want 00000000", d); end
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL rst_read_resp got %b want 00", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL rst_read_latency got %0d want 1", lat); end
    endtask

    task automatic test_same_cycle;
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        axi.axi4l_awaddr = 32'h08; axi.axi4l_awvalid = 1'b1;
        axi.axi4l_wdata = 32'hDEADBEEF; axi.axi4l_wstrb = 4'hF; axi.axi4l_wvalid = 1'b1;
        #1;
        checks++; if (axi.axi4l_awready !== 1'b1 || axi.axi4l_wready !== 1'b1) begin errors++; $display("FAIL sc_ready got aw=%b w=%b want 1", axi.axi4l_awready, axi.axi4l_wready); end
        tick();
        axi.axi4l_awvalid = 1'b0; axi.axi4l_wvalid = 1'b0;
        checks++; if (axi.axi4l_bvalid !== 1'b1) begin errors++; $display("FAIL sc_bvalid got %b want 1", axi.axi4l_bvalid); end
        checks++; if (axi.axi4l_bresp !== 2'b00) begin errors++; $display("FAIL sc_bresp got %b want 00", axi.axi4l_bresp); end
        checks++; if (axi.axi4l_awready !== 1'b0 || axi.axi4l_wready !== 1'b0) begin errors++; $display("FAIL sc_ready_blocked got aw=%b w=%b want 0", axi.axi4l_awready, axi.axi4l_wready); end
        axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_bready = 1'b0;
        checks++; if (axi.axi4l_bvalid !== 1'b0) begin errors++; $display("FAIL sc_bclear got %b want 0", axi.axi4l_bvalid); end
        read_txn(32'h08, d, r, lat, ok);
        checks++; if (!ok || d !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_readback got %h ok=%0d want deadbeef", d, ok); end
    endtask

    task automatic test_order;
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        // W leads AW by three cycles
        axi.axi4l_wdata = 32'h12345678; axi.axi4l_wstrb = 4'hF; axi.axi4l_wvalid = 1'b1;
        tick();
        axi.axi4l_wvalid = 1'b0;
        checks++; if (axi.axi4l_wready !== 1'b0 || axi.axi4l_awready !== 1'b1) begin errors++; $display("FAIL wfirst_ready got aw=%b w=%b want aw=1 w=0", axi.axi4l_awready, axi.axi4l_wready); end
        repeat (2) tick();
        checks++; if (axi.axi4l_bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_early_b got %b want 0", axi.axi4l_bvalid); end
        axi.axi4l_awaddr = 32'h0C; axi.axi4l_awvalid = 1'b1;
        tick();
        axi.axi4l_awvalid = 1'b0;
        checks++; if (axi.axi4l_bvalid !== 1'b1) begin errors++; $display("FAIL wfirst_bvalid got %b want 1", axi.axi4l_bvalid); end
        axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_bready = 1'b0;
        tick();
        checks++; if (axi.axi4l_bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_single_b got %b want 0", axi.axi4l_bvalid); end
        // AW leads W by two cycles
        axi.axi4l_awaddr = 32'h10; axi.axi4l_awvalid = 1'b1;
        tick();
        axi.axi4l_awvalid = 1'b0;
        checks++; if (axi.axi4l_awready !== 1'b0 || axi.axi4l_wready !== 1'b1) begin errors++; $display("FAIL awfirst_ready got aw=%b w=%b want aw=0 w=1", axi.axi4l_awready, axi.axi4l_wready); end
        tick();
        checks++; if (axi.axi4l_bvalid !== 1'b0) begin errors++; $display("FAIL awfirst_early_b got %b want 0", axi.axi4l_bvalid); end
        axi.axi4l_wdata = 32'hCAFEF00D; axi.axi4l_wvalid = 1'b1;
        tick();
        axi.axi4l_wvalid = 1'b0;
        checks++; if (axi.axi4l_bvalid !== 1'b1 || axi.axi4l_bresp !== 2'b00) begin errors++; $display("FAIL awfirst_b got v=%b r=%b want 1/00", axi.axi4l_bvalid, axi.axi4l_bresp); end
        axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_bready = 1'b0;
        read_txn(32'h0C, d, r, lat, ok);
        checks++; if (!ok || d !== 32'h12345678) begin errors++; $display("FAIL order_rb_0c got %h want 12345678", d); end
        read_txn(32'h10, d, r, lat, ok);
        checks++; if (!ok || d !== 32'hCAFEF00D) begin errors++; $display("FAIL order_rb_10 got %h want cafef00d", d); end
    endtask

    task automatic test_strobe;
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        write_txn(32'h14, 32'hFFFFFFFF, 4'hF, r, ok);
        write_txn(32'h14, 32'hAABBCCDD, 4'h5, r, ok);
        checks++; if (!ok || r !== 2'b00) begin errors++; $display("FAIL strb_resp got %b ok=%0d want 00", r, ok); end
        read_txn(32'h14, d, r, lat, ok);
        checks++; if (d !== 32'hFFBBFFDD) begin errors++; $display("FAIL strb_merge got %h want ffbbffdd", d); end
        write_txn(32'h14, 32'h12345678, 4'h0, r, ok);
        checks++; if (!ok || r !== 2'b00) begin errors++; $display("FAIL strb0_resp got %b ok=%0d want 00", r, ok); end
        read_txn(32'h14, d, r, lat, ok);
        checks++; if (d !== 32'hFFBBFFDD) begin errors++; $display("FAIL strb0_unchanged got %h want ffbbffdd", d); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        axi.axi4l_awaddr = 32'h18; axi.axi4l_awvalid = 1'b1;
        axi.axi4l_wdata = 32'h00000055; axi.axi4l_wstrb = 4'hF; axi.axi4l_wvalid = 1'b1;
        tick();
        // next write is offered immediately and must wait out the stalled response
        axi.axi4l_awaddr = 32'h1C; axi.axi4l_wdata = 32'h0000AAAA;
        for (int i = 0; i < 5; i++) begin
            checks++; if (axi.axi4l_bvalid !== 1'b1) begin errors++; $display("FAIL bp_bvalid[%0d] got %b want 1", i, axi.axi4l_bvalid); end
            checks++; if (axi.axi4l_awready !== 1'b0 || axi.axi4l_wready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got aw=%b w=%b want 0", i, axi.axi4l_awready, axi.axi4l_wready); end
            tick();
        end
        axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_bready = 1'b0;
        checks++; if (axi.axi4l_bvalid !== 1'b0 || axi.axi4l_awready !== 1'b1) begin errors++; $display("FAIL bp_release got b=%b aw=%b want b=0 aw=1", axi.axi4l_bvalid, axi.axi4l_awready); end
        tick();
        axi.axi4l_awvalid = 1'b0; axi.axi4l_wvalid = 1'b0;
        checks++; if (axi.axi4l_bvalid !== 1'b1) begin errors++; $display("FAIL bp_second_b got %b want 1", axi.axi4l_bvalid); end
        axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_bready = 1'b0;
        read_txn(32'h18, d, r, lat, ok);
        checks++; if (d !== 32'h00000055) begin errors++; $display("FAIL bp_rb_18 got %h want 00000055", d); end
        read_txn(32'h1C, d, r, lat, ok);
        checks++; if (d !== 32'h0000AAAA) begin errors++; $display("FAIL bp_rb_1c got %h want 0000aaaa", d); end
    endtask

    task automatic test_concurrent;
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        axi.axi4l_awaddr = 32'h08; axi.axi4l_awvalid = 1'b1;
        axi.axi4l_wdata = 32'h01020304; axi.axi4l_wstrb = 4'hF; axi.axi4l_wvalid = 1'b1;
        axi.axi4l_araddr = 32'h08; axi.axi4l_arvalid = 1'b1;
        tick();
        axi.axi4l_awvalid = 1'b0; axi.axi4l_wvalid = 1'b0; axi.axi4l_arvalid = 1'b0;
        checks++; if (axi.axi4l_rvalid !== 1'b1 || axi.axi4l_bvalid !== 1'b1) begin errors++; $display("FAIL cc_valids got r=%b b=%b want 1", axi.axi4l_rvalid, axi.axi4l_bvalid); end
        checks++; if (axi.axi4l_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cc_prewrite got %h want deadbeef", axi.axi4l_rdata); end
        repeat (3) tick();
        checks++; if (axi.axi4l_rvalid !== 1'b1 || axi.axi4l_arready !== 1'b0 || axi.axi4l_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL cc_rhold got v=%b ar=%b d=%h want 1/0/deadbeef", axi.axi4l_rvalid, axi.axi4l_arready, axi.axi4l_rdata); end
        axi.axi4l_rready = 1'b1; axi.axi4l_bready = 1'b1;
        tick();
        axi.axi4l_rready = 1'b0; axi.axi4l_bready = 1'b0;
        checks++; if (axi.axi4l_rvalid !== 1'b0 || axi.axi4l_bvalid !== 1'b0) begin errors++; $display("FAIL cc_clear got r=%b b=%b want 0", axi.axi4l_rvalid, axi.axi4l_bvalid); end
        read_txn(32'h0B, d, r, lat, ok);
        checks++; if (!ok || d !== 32'h01020304) begin errors++; $display("FAIL cc_unaligned_rb got %h want 01020304", d); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d; logic [1:0] r; logic [1:0] wr_r; int lat; bit ok;
        write_txn(32'h100, 32'h77777777, 4'hF, wr_r, ok);
`ifdef AXI4L_IF_SLVERR_EN
        checks++; if (!ok || wr_r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b want 10", wr_r); end
        read_txn(32'h00, d, r, lat, ok);
        checks++; if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL oor_reg0 got %h/%b want 00000000/00", d, r); end
        read_txn(32'h100, d, r, lat, ok);
        checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read got %h/%b want 00000000/10", d, r); end
`else
        checks++; if (!ok || wr_r !== 2'b00) begin errors++; $display("FAIL alias_bresp got %b want 00", wr_r); end
        read_txn(32'h00, d, r, lat, ok);
        checks++; if (d !== 32'h77777777 || r !== 2'b00) begin errors++; $display("FAIL alias_reg0 got %h/%b want 77777777/00", d, r); end
        read_txn(32'h100, d, r, lat, ok);
        checks++; if (d !== 32'h77777777 || r !== 2'b00) begin errors++; $display("FAIL alias_read got %h/%b want 77777777/00", d, r); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        axi.axi4l_awaddr = '0; axi.axi4l_awprot = '0; axi.axi4l_awvalid = 1'b0;
        axi.axi4l_wdata  = '0; axi.axi4l_wstrb  = '0; axi.axi4l_wvalid  = 1'b0;
        axi.axi4l_bready = 1'b0;
        axi.axi4l_araddr = '0; axi.axi4l_arprot = '0; axi.axi4l_arvalid = 1'b0;
        axi.axi4l_rready = 1'b0;
        test_reset();
        test_same_cycle();
        test_order();
        test_strobe();
        test_backpressure();
        test_concurrent();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4l_if.md
AXI4L_IF -- requirements
Module: axi4l_if

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers; power of two, 2 to 256.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named as below.
- axi4l_aclk  in  1  sole clock; all logic on rising edge.
- axi4l_arstn  in  1  synchronous active-high reset; the name is retained for codebase consistency.
- axi4l_awaddr  in  ADDR_WIDTH  write address.
- axi4l_awprot  in  3  ignored.
- axi4l_awvalid / axi4l_awready  in / out  1  write-address handshake.
- axi4l_wdata  in  DATA_WIDTH  write data.
- axi4l_wstrb  in  DATA_WIDTH/8  byte-lane enables.
- axi4l_wvalid / axi4l_wready  in / out  1  write-data handshake.
- axi4l_bresp  out  2  write response.
- axi4l_bvalid / axi4l_bready  out / in  1  write-response handshake.
- axi4l_araddr  in  ADDR_WIDTH  read address.
- axi4l_arprot  in  3  ignored.
- axi4l_arvalid / axi4l_arready  in / out  1  read-address handshake.
- axi4l_rdata  out  DATA_WIDTH  read data.
- axi4l_rresp  out  2  read response.
- axi4l_rvalid / axi4l_rready  out / in  1  read-data handshake.

Function
REQ-005 SHALL implement an AXI4-Lite slave holding NUM_REGS read/write registers; register index = addr[log2(NUM_REGS)+1:2], and addr[1:0] SHALL be ignored.
REQ-006 SHALL drive awready = ~aw_held & ~bvalid and wready = ~w_held & ~bvalid; AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-007 SHALL commit the write and set bvalid on the clock edge where the second of AW and W is accepted; on that same edge, aw_held and w_held SHALL be cleared.
REQ-008 SHALL update only the byte lanes whose wstrb bit is 1; wstrb=0 SHALL leave the register unchanged but still produce a response.
REQ-009 SHALL hold bvalid and bresp stable until bready; bvalid SHALL clear on the edge where bvalid&bready; no AW or W is accepted while bvalid=1.
REQ-010 SHALL drive arready = ~rvalid; on an edge with arvalid&arready, it SHALL register rdata and rresp and set rvalid (one-cycle latency).
REQ-011 SHALL hold rdata, rresp and rvalid stable until rready; rvalid SHALL clear on the edge where rvalid&rready (maximum one read per two cycles).
REQ-012 SHALL return the pre-write value when a read and a write to the same register complete on the same edge.
REQ-013 SHALL operate the read and write paths concurrently without mutual blocking.
REQ-014 SHALL respond OKAY (2'b00) on all in-range accesses.

Reset
REQ-015 While axi4l_arstn=1 at an edge, all registers SHALL clear to 0, and aw_held, w_held, bvalid and rvalid SHALL clear.
REQ-016 While in reset, awready, wready and arready SHALL be 0, bresp, rresp and rdata SHALL be 0, and any in-flight transaction SHALL be discarded.
REQ-017 awready, wready and arready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-018 With macro AXI4L_IF_SLVERR_EN defined, an access with addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] nonzero is out of range and SHALL get SLVERR (2'b10), with the write discarded and rdata=0.
REQ-019 With AXI4L_IF_SLVERR_EN undefined, upper address bits SHALL be ignored (aliasing), and the response SHALL always be OKAY.

Verification
REQ-020 A bench SHALL cover the following directed scenarios:
- Reset for 10 cycles, then read addr 0x04 -> rdata=0x00000000, rresp=OKAY, rvalid one cycle after the AR handshake.
- Same-cycle AW/W to 0x08, data 0xDEADBEEF, wstrb 0xF; read back -> bvalid on the next edge, bresp=OKAY, readback 0xDEADBEEF.
- W before AW by 3 cycles, 0x0C, 0x12345678; then AW before W, 0x10 -> both complete once, with correct readback.
- Write 0xFFFFFFFF to 0x14, then 0xAABBCCDD with wstrb 0x5 -> readback 0xFFBBFFDD.
- Hold bready=0 for 5 cycles -> bvalid stays 1 and awready/wready stay 0 until the handshake.
- With AXI4L_IF_SLVERR_EN, write to 0x100 -> bresp=2'b10 and registers unchanged; without the macro, the write aliases to reg 0.
